// File: rtl/aes_key_schedule_multi.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_schedule_multi
// Function : AES-128/192/256 key expansion, one schedule word per cycle, with a
//            randomly readable round-key store. Optional macro AES_EQINV_KEYS_EN
//            adds the eqinv read mode (InvMixColumns on inner round keys).
// Revision : 1.0 - initial release
// ============================================================================

package aes_key_schedule_multi_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] d);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = d[127-32*c -: 8];
            a1 = d[119-32*c -: 8];
            a2 = d[111-32*c -: 8];
            a3 = d[103-32*c -: 8];
            r[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            r[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            r[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            r[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return r;
    endfunction

endpackage

// ============================================================================
// Module   : aes_key_schedule_multi_sbox
// Function : combinational AES S-box (field inverse followed by affine map)
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_schedule_multi_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    import aes_key_schedule_multi_pkg::*;

    logic [7:0] w_inv;

    assign w_inv = gf_inv(a);
    assign s     = w_inv
                 ^ {w_inv[6:0], w_inv[7]}
                 ^ {w_inv[5:0], w_inv[7:6]}
                 ^ {w_inv[4:0], w_inv[7:5]}
                 ^ {w_inv[3:0], w_inv[7:4]}
                 ^ 8'h63;
endmodule

// ============================================================================
// Module   : aes_key_schedule_multi
// Function : key-expansion engine top level
// Revision : 1.0 - initial release
// ============================================================================
module aes_key_schedule_multi #(
    parameter int NK_MAX   = 8,
    parameter int RK_DEPTH = NK_MAX + 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            key_len,
    input  logic [32*NK_MAX-1:0]  key,
`ifdef AES_EQINV_KEYS_EN
    input  logic                  eqinv,
`endif
    output logic                  busy,
    output logic                  err,
    output logic                  rk_valid,
    output logic [3:0]            rk_idx,
    output logic [127:0]          rk_data,
    output logic                  done,
    input  logic [3:0]            rd_idx,
    output logic [127:0]          rd_key
);
    import aes_key_schedule_multi_pkg::*;

    localparam logic [3:0] c_nk_max = 4'(NK_MAX);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_EXPAND = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic                  w_accept, w_reject;

    logic [3:0]            w_nk, w_nr;
    logic                  w_bad;

    logic [32*NK_MAX-1:0]  r_key;
    logic [3:0]            r_nk, r_nr;
    logic [2:0]            r_nkm1, r_mod;
    logic [5:0]            r_i, r_last;
    logic [7:0]            r_rcon;
    logic [31:0]           r_hist [8];

    logic                  r_busy, r_err, r_rk_valid, r_done;
    logic [3:0]            r_rk_idx;
    logic [127:0]          r_rk_data, r_rd_key;
    logic [127:0]          r_store [RK_DEPTH];

    logic                  w_in_key;
    logic [31:0]           w_prev, w_old, w_rot, w_sub_in, w_sub_out, w_t, w_word;
    logic [127:0]          w_rd_raw, w_rd_val;

    always_comb begin
        w_nk  = 4'd4;
        w_nr  = 4'd10;
        w_bad = 1'b0;
        case (key_len)
            2'b00:   begin w_nk = 4'd4; w_nr = 4'd10; end
            2'b01:   begin w_nk = 4'd6; w_nr = 4'd12; end
            2'b10:   begin w_nk = 4'd8; w_nr = 4'd14; end
            default: w_bad = 1'b1;
        endcase
        if (w_nk > c_nk_max) w_bad = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_bad) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept    = 1'b1;
                        w_state_nxt = S_EXPAND;
                    end
                end
            end
            S_EXPAND: begin
                if (r_i == r_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // r_hist[0] is w[i-1]; r_hist[Nk-1] is w[i-Nk]. Key words shift out of r_key MSB-first.
    assign w_in_key = (r_i < {2'b00, r_nk});
    assign w_prev   = r_hist[0];
    assign w_old    = r_hist[r_nkm1];
    assign w_rot    = {w_prev[23:0], w_prev[31:24]};
    assign w_sub_in = (r_mod == 3'd0) ? w_rot : w_prev;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_key_schedule_multi_sbox u_sbox (
            .a (w_sub_in[8*g+7:8*g]),
            .s (w_sub_out[8*g+7:8*g])
        );
    end

    always_comb begin
        w_t = w_prev;
        if (r_mod == 3'd0)
            w_t = w_sub_out ^ {r_rcon, 24'h000000};
        else if (r_nk == 4'd8 && r_mod == 3'd4)
            w_t = w_sub_out;
        w_word = w_in_key ? r_key[32*NK_MAX-1 -: 32] : (w_old ^ w_t);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key      <= '0;
            r_nk       <= 4'd0;
            r_nr       <= 4'd0;
            r_nkm1     <= 3'd0;
            r_mod      <= 3'd0;
            r_i        <= 6'd0;
            r_last     <= 6'd0;
            r_rcon     <= 8'h01;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;
            r_rk_idx   <= 4'd0;
            r_rk_data  <= '0;
            for (int k = 0; k < 8; k++) r_hist[k] <= '0;
        end else begin
            r_err      <= w_reject;
            r_rk_valid <= 1'b0;
            r_done     <= 1'b0;
            if (w_accept) begin
                r_key  <= key;
                r_nk   <= w_nk;
                r_nr   <= w_nr;
                r_nkm1 <= 3'(w_nk - 4'd1);
                r_last <= {w_nr, 2'b11};
                r_i    <= 6'd0;
                r_mod  <= 3'd0;
                r_rcon <= 8'h01;
                r_busy <= 1'b1;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end
            if (r_state == S_EXPAND) begin
                r_hist[0] <= w_word;
                for (int k = 1; k < 8; k++) r_hist[k] <= r_hist[k-1];
                r_key <= r_key << 32;
                r_i   <= r_i + 6'd1;
                r_mod <= (r_mod == r_nkm1) ? 3'd0 : r_mod + 3'd1;
                if (!w_in_key && r_mod == 3'd0) r_rcon <= xtime(r_rcon);
                if (r_i[1:0] == 2'b11) begin
                    r_rk_valid <= 1'b1;
                    r_rk_idx   <= r_i[5:2];
                    r_rk_data  <= {r_hist[2], r_hist[1], r_hist[0], w_word};
                    r_done     <= (r_i == r_last);
                end
            end
        end
    end

    // Entries beyond the current run's Nr read as zero even if an older run left data there
    always_comb begin
        w_rd_raw = '0;
        if (rd_idx <= r_nr) w_rd_raw = r_store[rd_idx];
        w_rd_val = w_rd_raw;
`ifdef AES_EQINV_KEYS_EN
        if (eqinv && rd_idx != 4'd0 && rd_idx != r_nr) w_rd_val = inv_mix_columns(w_rd_raw);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_key <= '0;
            for (int k = 0; k < RK_DEPTH; k++) r_store[k] <= '0;
        end else begin
            r_rd_key <= w_rd_val;
            if (r_rk_valid) r_store[r_rk_idx] <= r_rk_data;
        end
    end

    assign busy     = r_busy;
    assign err      = r_err;
    assign rk_valid = r_rk_valid;
    assign rk_idx   = r_rk_idx;
    assign rk_data  = r_rk_data;
    assign done     = r_done;
    assign rd_key   = r_rd_key;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_key_schedule_multi
// Function : directed self-checking bench for aes_key_schedule_multi
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_key_schedule_multi;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key;
    logic         busy, err, rk_valid, done;
    logic [3:0]   rk_idx, rd_idx;
    logic [127:0] rk_data, rd_key;
`ifdef AES_EQINV_KEYS_EN
    logic         eqinv;
`endif

    int           n_checks = 0;
    int           n_errors = 0;
    logic [127:0] rk_seen [16];

    always #5 clk = ~clk;

    aes_key_schedule_multi #(.NK_MAX(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .key_len  (key_len),
        .key      (key),
`ifdef AES_EQINV_KEYS_EN
        .eqinv    (eqinv),
`endif
        .busy     (busy),
        .err      (err),
        .rk_valid (rk_valid),
        .rk_idx   (rk_idx),
        .rk_data  (rk_data),
        .done     (done),
        .rd_idx   (rd_idx),
        .rd_key   (rd_key)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward MixColumns: undoes the eqinv transform to recover the raw key
    function automatic logic [127:0] mix_columns(input logic [127:0] d);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = d[127-32*c -: 8];
            a1 = d[119-32*c -: 8];
            a2 = d[111-32*c -: 8];
            a3 = d[103-32*c -: 8];
            r[127-32*c -: 8] = xt(a0) ^ (xt(a1) ^ a1) ^ a2 ^ a3;
            r[119-32*c -: 8] = a0 ^ xt(a1) ^ (xt(a2) ^ a2) ^ a3;
            r[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ (xt(a3) ^ a3);
            r[103-32*c -: 8] = (xt(a0) ^ a0) ^ a1 ^ a2 ^ xt(a3);
        end
        return r;
    endfunction

    // Cycle 0 = start high; loop index c counts cycles after it.
    task automatic run_key(input logic [1:0] kl, input logic [255:0] k, input bit inject,
                           output int pulses, output int done_cyc, output int busy_low_cyc,
                           output bit saw_err, output bit busy_c1, output bit done_valid);
        pulses = 0; done_cyc = -1; busy_low_cyc = -1;
        saw_err = 1'b0; busy_c1 = 1'b0; done_valid = 1'b0;
        for (int j = 0; j < 16; j++) rk_seen[j] = '0;
        key = k; key_len = kl; start = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin start = 1'b0; busy_c1 = busy; end
            if (inject && c == 10) begin start = 1'b1; key_len = 2'b10; key = ~k; end
            if (inject && c == 11) begin start = 1'b0; key_len = kl; key = k; end
            if (rk_valid) begin pulses++; rk_seen[rk_idx] = rk_data; end
            if (err) saw_err = 1'b1;
            if (done && done_cyc < 0) begin done_cyc = c; done_valid = rk_valid; end
            if (done_cyc >= 0 && !busy) begin busy_low_cyc = c; break; end
        end
    endtask

    int p, dc, bl;
    bit se, b1, dv;

    initial begin
        reset = 1'b1; start = 1'b0; key_len = 2'b00; key = '0; rd_idx = 4'd0;
`ifdef AES_EQINV_KEYS_EN
        eqinv = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",     128'(busy),     128'd0);
        check("reset_err",      128'(err),      128'd0);
        check("reset_rk_valid", 128'(rk_valid), 128'd0);
        check("reset_done",     128'(done),     128'd0);
        check("reset_rk_idx",   128'(rk_idx),   128'd0);
        check("reset_rk_data",  rk_data,        128'd0);
        check("reset_rd_key",   rd_key,         128'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Illegal key length
        key_len = 2'b11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("illegal_err_c1",  128'(err),  128'd1);
        check("illegal_busy_c1", 128'(busy), 128'd0);
        @(posedge clk); #1;
        check("illegal_err_c2",  128'(err),  128'd0);
        se = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rk_valid || busy || err) se = 1'b1;
        end
        check("illegal_quiet", 128'(se), 128'd0);

        // AES-128 with a second start injected during EXPAND
        run_key(2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b1, p, dc, bl, se, b1, dv);
        check("a128_busy_c1",  128'(b1), 128'd1);
        check("a128_pulses",   128'(p),  128'd11);
        check("a128_done_cyc", 128'(dc), 128'd45);
        check("a128_done_vld", 128'(dv), 128'd1);
        check("a128_busy_low", 128'(bl), 128'd46);
        check("a128_no_err",   128'(se), 128'd0);
        check("a128_rk0",  rk_seen[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("a128_rk1",  rk_seen[1],  128'ha0fafe1788542cb123a339392a6c7605);
        check("a128_rk2",  rk_seen[2],  128'hf2c295f27a96b9435935807a7359f67f);
        check("a128_rk9",  rk_seen[9],  128'hac7766f319fadc2128d12941575c006e);
        check("a128_rk10", rk_seen[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // AES-192
        run_key(2'b01, {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 1'b0, p, dc, bl, se, b1, dv);
        check("a192_pulses",   128'(p),  128'd13);
        check("a192_done_cyc", 128'(dc), 128'd53);
        check("a192_busy_low", 128'(bl), 128'd54);
        check("a192_rk1",  rk_seen[1],  128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        check("a192_rk12", rk_seen[12], 128'he98ba06f448c773c8ecc720401002202);

        // AES-256
        run_key(2'b10, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 1'b0, p, dc, bl, se, b1, dv);
        check("a256_pulses",   128'(p),  128'd15);
        check("a256_done_cyc", 128'(dc), 128'd61);
        check("a256_busy_low", 128'(bl), 128'd62);
        check("a256_rk0",  rk_seen[0],  128'h603deb1015ca71be2b73aef0857d7781);
        check("a256_rk1",  rk_seen[1],  128'h1f352c073b6108d72d9810a30914dff4);
        check("a256_rk2",  rk_seen[2],  128'h9ba354118e6925afa51a8b5f2067fcde);
        check("a256_rk14", rk_seen[14], 128'hfe4890d1e6188d0b046df344706c631e);

        // Reverse-order reads, one new address per cycle
        for (int r = 14; r >= 0; r--) begin
            rd_idx = 4'(r);
            @(posedge clk); #1;
            check($sformatf("a256_rd%0d", r), rd_key, rk_seen[r]);
            if (r == 14) check("a256_rd14_const", rd_key, 128'hfe4890d1e6188d0b046df344706c631e);
            if (r == 0)  check("a256_rd0_const",  rd_key, 128'h603deb1015ca71be2b73aef0857d7781);
        end
        rd_idx = 4'd15;
        @(posedge clk); #1;
        check("a256_rd15_zero", rd_key, 128'd0);

        // AES-128 again: entries above Nr=10 read as zero
        run_key(2'b00, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 1'b0, p, dc, bl, se, b1, dv);
        rd_idx = 4'd12;
        @(posedge clk); #1;
        check("a128b_rd12_zero", rd_key, 128'd0);
        rd_idx = 4'd10;
        @(posedge clk); #1;
        check("a128b_rd10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef AES_EQINV_KEYS_EN
        eqinv = 1'b1;
        rd_idx = 4'd0;
        @(posedge clk); #1;
        check("eqinv_rd0_raw", rd_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        rd_idx = 4'd10;
        @(posedge clk); #1;
        check("eqinv_rd10_raw", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd_idx = 4'd1;
        @(posedge clk); #1;
        check("eqinv_rd1_mix", mix_columns(rd_key), 128'ha0fafe1788542cb123a339392a6c7605);
        check("eqinv_rd1_differs", 128'(rd_key != 128'ha0fafe1788542cb123a339392a6c7605), 128'd1);
        eqinv = 1'b0;
`endif

        // Reset at word 20 (produced in cycle 21)
        rd_idx = 4'd0;
        key = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}; key_len = 2'b00; start = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
        end
        check("midrun_busy_before", 128'(busy), 128'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrun_busy",     128'(busy),     128'd0);
        check("midrun_err",      128'(err),      128'd0);
        check("midrun_rk_valid", 128'(rk_valid), 128'd0);
        check("midrun_done",     128'(done),     128'd0);
        check("midrun_rk_idx",   128'(rk_idx),   128'd0);
        check("midrun_rk_data",  rk_data,        128'd0);
        check("midrun_rd_key",   rd_key,         128'd0);
        reset = 1'b0;
        rd_idx = 4'd0;
        @(posedge clk); #1;
        check("midrun_rd0_cleared", rd_key, 128'd0);
        se = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (busy || rk_valid) se = 1'b1;
        end
        check("midrun_stays_idle", 128'(se), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
